// File: rtl/led_status_ctrl.sv
// Front-panel status LED controller: debounced fault pins, critical-fault latch,
// identify timer and a lamp-test sequencer that overrides the normal LED selection.
module led_status_ctrl #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int ID_TIMEOUT   = 60,
    parameter int LAMP_CYC     = 25000000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic CLK_1HZ,
    input  logic CLK_2HZ,
    input  logic CLK_4HZ,
    input  logic CLK_4HZ_3500MS,
    input  logic CLK_07S,
    input  logic POWER_GOOD,
    input  logic FAULT_CRIT_N,
    input  logic FAULT_WARN_N,
    input  logic CLR_FAULT,
    input  logic ID_REQ,
    input  logic LAMP_TEST,
    output logic LED_AMBER,
    output logic LED_GREEN,
    output logic LED_BLUE,
    output logic FAULT_LATCHED,
    output logic LAMP_BUSY
);

    localparam int          DEB_LAST_I  = DEBOUNCE_CYC - 1;
    localparam logic [15:0] DEB_LAST    = DEB_LAST_I[15:0];
    localparam int          ID_LAST_I   = (ID_TIMEOUT == 0) ? 0 : ID_TIMEOUT - 1;
    localparam logic [7:0]  ID_LAST     = ID_LAST_I[7:0];
    localparam int          LAMP_LAST_I = LAMP_CYC - 1;
    localparam logic [24:0] LAMP_LAST   = LAMP_LAST_I[24:0];

    typedef enum logic [2:0] {
        LAMP_IDLE,
        LAMP_ALL_ON,
        LAMP_AMBER,
        LAMP_GREEN,
        LAMP_BLUE
    } lamp_state_t;

    // Bit 0 carries the critical pin, bit 1 the warning pin.
    logic [1:0]  r_syncA;
    logic [1:0]  r_syncB;
    logic [1:0]  r_deb;
    logic [15:0] r_debCnt [2];
    logic [1:0]  w_raw;
    logic [1:0]  w_debNext;

    logic        r_faultLatched;
    logic        r_idReqD;
    logic        r_clk1hzD;
    logic        r_idActive;
    logic [7:0]  r_idCnt;
    logic        w_idRise;
    logic        w_1hzRise;
    logic        w_idTimeout;

    lamp_state_t r_lampState;
    lamp_state_t w_lampNext;
    logic [24:0] r_lampCnt;
    logic [24:0] w_lampCntNext;

    logic        r_ledAmber;
    logic        r_ledGreen;
    logic        r_ledBlue;
    logic        w_amber;
    logic        w_green;
    logic        w_blue;

    assign w_raw = ~r_syncB;

    always_comb begin
        w_debNext = r_deb;
        for (int i = 0; i < 2; i++) begin
            if (w_raw[i] != r_deb[i] && r_debCnt[i] == DEB_LAST) begin
                w_debNext[i] = w_raw[i];
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            r_syncA <= 2'b11;
            r_syncB <= 2'b11;
            r_deb   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_debCnt[i] <= '0;
            end
        end else begin
            r_syncA <= {FAULT_WARN_N, FAULT_CRIT_N};
            r_syncB <= r_syncA;
            r_deb   <= w_debNext;
            for (int i = 0; i < 2; i++) begin
                if (w_raw[i] == r_deb[i] || r_debCnt[i] == DEB_LAST) begin
                    r_debCnt[i] <= '0;
                end else begin
                    r_debCnt[i] <= r_debCnt[i] + 16'd1;
                end
            end
        end
    end

    // Latch on the freshly accepted level so it rises in the same cycle as the debounce.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            r_faultLatched <= 1'b0;
        end else if (w_debNext[0]) begin
            r_faultLatched <= 1'b1;
        end else if (CLR_FAULT && !r_deb[0]) begin
            r_faultLatched <= 1'b0;
        end
    end

    assign w_idRise    = ID_REQ & ~r_idReqD;
    assign w_1hzRise   = CLK_1HZ & ~r_clk1hzD;
    assign w_idTimeout = (ID_TIMEOUT != 0) && r_idActive && w_1hzRise && (r_idCnt == ID_LAST);

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            r_idReqD   <= 1'b0;
            r_clk1hzD  <= 1'b0;
            r_idActive <= 1'b0;
            r_idCnt    <= '0;
        end else begin
            r_idReqD  <= ID_REQ;
            r_clk1hzD <= CLK_1HZ;
            if (w_idTimeout) begin
                r_idActive <= 1'b0;
                r_idCnt    <= '0;
            end else if (w_idRise) begin
                r_idActive <= ~r_idActive;
                r_idCnt    <= '0;
            end else if (r_idActive && w_1hzRise) begin
                r_idCnt <= r_idCnt + 8'd1;
            end
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            r_lampState <= LAMP_IDLE;
            r_lampCnt   <= '0;
        end else begin
            r_lampState <= w_lampNext;
            r_lampCnt   <= w_lampCntNext;
        end
    end

    always_comb begin
        w_lampNext    = r_lampState;
        w_lampCntNext = '0;
        if (r_lampState == LAMP_IDLE) begin
            if (LAMP_TEST) begin
                w_lampNext = LAMP_ALL_ON;
            end
        end else if (r_lampCnt == LAMP_LAST) begin
            case (r_lampState)
                LAMP_ALL_ON: w_lampNext = LAMP_AMBER;
                LAMP_AMBER:  w_lampNext = LAMP_GREEN;
                LAMP_GREEN:  w_lampNext = LAMP_BLUE;
                default:     w_lampNext = LAMP_IDLE;
            endcase
        end else begin
            w_lampCntNext = r_lampCnt + 25'd1;
        end
    end

    always_comb begin
        w_amber = 1'b0;
        w_green = 1'b0;
        w_blue  = 1'b0;
        case (r_lampState)
            LAMP_ALL_ON: begin
                w_amber = 1'b1;
                w_green = 1'b1;
                w_blue  = 1'b1;
            end
            LAMP_AMBER: w_amber = 1'b1;
            LAMP_GREEN: w_green = 1'b1;
            LAMP_BLUE:  w_blue  = 1'b1;
            default: begin
                if (r_faultLatched) begin
                    w_amber = CLK_4HZ;
                end else if (r_deb[1]) begin
                    w_amber = CLK_4HZ_3500MS;
                end else if (!POWER_GOOD) begin
                    w_green = CLK_07S;
                end else begin
                    w_green = 1'b1;
                end
                w_blue = r_idActive & CLK_2HZ;
            end
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            r_ledAmber <= ACTIVE_LOW;
            r_ledGreen <= ACTIVE_LOW;
            r_ledBlue  <= ACTIVE_LOW;
        end else begin
            r_ledAmber <= w_amber ^ ACTIVE_LOW;
            r_ledGreen <= w_green ^ ACTIVE_LOW;
            r_ledBlue  <= w_blue ^ ACTIVE_LOW;
        end
    end

    assign LED_AMBER     = r_ledAmber;
    assign LED_GREEN     = r_ledGreen;
    assign LED_BLUE      = r_ledBlue;
    assign FAULT_LATCHED = r_faultLatched;
    assign LAMP_BUSY     = (r_lampState != LAMP_IDLE);

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl; stimulus queues expected output vectors
// tagged with a cycle number and a monitor compares them on the falling edge.
module tb_led_status_ctrl;

    logic SYSCLK;
    logic RESET;
    logic CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_4HZ_3500MS, CLK_07S;
    logic POWER_GOOD, FAULT_CRIT_N, FAULT_WARN_N;
    logic CLR_FAULT, ID_REQ, LAMP_TEST;
    logic LED_AMBER, LED_GREEN, LED_BLUE, FAULT_LATCHED, LAMP_BUSY;

    int          cycNum = 0;
    int          checks = 0;
    int          errors = 0;
    int          cycQ[$];
    string       nameQ[$];
    logic [4:0]  expQ[$];
    logic [4:0]  maskQ[$];
    logic [4:0]  obs;

    led_status_ctrl #(
        .DEBOUNCE_CYC(4),
        .ID_TIMEOUT(3),
        .LAMP_CYC(5),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .SYSCLK(SYSCLK),
        .RESET(RESET),
        .CLK_1HZ(CLK_1HZ),
        .CLK_2HZ(CLK_2HZ),
        .CLK_4HZ(CLK_4HZ),
        .CLK_4HZ_3500MS(CLK_4HZ_3500MS),
        .CLK_07S(CLK_07S),
        .POWER_GOOD(POWER_GOOD),
        .FAULT_CRIT_N(FAULT_CRIT_N),
        .FAULT_WARN_N(FAULT_WARN_N),
        .CLR_FAULT(CLR_FAULT),
        .ID_REQ(ID_REQ),
        .LAMP_TEST(LAMP_TEST),
        .LED_AMBER(LED_AMBER),
        .LED_GREEN(LED_GREEN),
        .LED_BLUE(LED_BLUE),
        .FAULT_LATCHED(FAULT_LATCHED),
        .LAMP_BUSY(LAMP_BUSY)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    always @(posedge SYSCLK) cycNum <= cycNum + 1;

    // Vector layout: {LAMP_BUSY, FAULT_LATCHED, LED_BLUE, LED_GREEN, LED_AMBER}.
    assign obs = {LAMP_BUSY, FAULT_LATCHED, LED_BLUE, LED_GREEN, LED_AMBER};

    always @(negedge SYSCLK) begin : monitor
        int i;
        i = 0;
        while (i < cycQ.size()) begin
            if (cycQ[i] <= cycNum) begin
                checks++;
                if (cycQ[i] < cycNum || ((obs ^ expQ[i]) & maskQ[i]) !== 5'b0) begin
                    errors++;
                    $display("[TB] FAIL %s cycle %0d actual %b required %b mask %b",
                             nameQ[i], cycNum, obs, expQ[i], maskQ[i]);
                end
                cycQ.delete(i);
                nameQ.delete(i);
                expQ.delete(i);
                maskQ.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    task automatic checkOutput(input int d, input string nm, input logic [4:0] exp, input logic [4:0] mask);
        cycQ.push_back(cycNum + d);
        nameQ.push_back(nm);
        expQ.push_back(exp);
        maskQ.push_back(mask);
    endtask

    // Expected vector d cycles after a LAMP_TEST pulse is driven (LAMP_CYC = 5).
    function automatic logic [4:0] lampExp(input int d, input logic [4:0] normal);
        logic [2:0] leds;
        logic       busy;
        busy = (d >= 1 && d <= 20);
        if (d <= 1 || d >= 22) leds = normal[2:0];
        else if (d <= 6)       leds = 3'b000;
        else if (d <= 11)      leds = 3'b110;
        else if (d <= 16)      leds = 3'b101;
        else                   leds = 3'b011;
        return {busy, normal[3], leds};
    endfunction

    initial begin
        logic v;
        logic [4:0] pat;
        RESET = 1'b1;
        CLK_1HZ = 0; CLK_2HZ = 0; CLK_4HZ = 0; CLK_4HZ_3500MS = 0; CLK_07S = 0;
        POWER_GOOD = 1; FAULT_CRIT_N = 1; FAULT_WARN_N = 1;
        CLR_FAULT = 0; ID_REQ = 0; LAMP_TEST = 0;
        applyStimulus(2);
        checkOutput(0, "resetState", 5'b00111, 5'b11111);
        RESET = 1'b0;
        checkOutput(1, "powerGood", 5'b00101, 5'b11111);
        checkOutput(3, "powerGoodSteady", 5'b00101, 5'b11111);
        applyStimulus(3);

        // Standby: green follows CLK_07S one cycle later.
        POWER_GOOD = 0;
        pat = 5'b01101;
        for (int k = 0; k < 5; k++) begin
            v = pat[k];
            CLK_07S = v;
            checkOutput(1, "standby", {3'b001, ~v, 1'b1}, 5'b11111);
            applyStimulus(1);
        end
        POWER_GOOD = 1;
        applyStimulus(2);

        // Three-cycle glitch must not latch.
        FAULT_CRIT_N = 0;
        applyStimulus(3);
        FAULT_CRIT_N = 1;
        for (int d = 1; d <= 8; d++) checkOutput(d, "glitchNoLatch", 5'b00000, 5'b01000);
        applyStimulus(8);

        // Held fault latches exactly 6 cycles after the pin edge.
        FAULT_CRIT_N = 0;
        checkOutput(5, "latchNotEarly", 5'b00000, 5'b01000);
        checkOutput(6, "latchAt6", 5'b01000, 5'b01000);
        applyStimulus(6);
        pat = 5'b01101;
        for (int k = 0; k < 5; k++) begin
            v = pat[k];
            CLK_4HZ = v;
            checkOutput(1, "critAmber", {4'b0111, ~v}, 5'b11111);
            applyStimulus(1);
        end
        CLR_FAULT = 1;
        checkOutput(1, "clrIgnored", 5'b01000, 5'b01000);
        applyStimulus(1);
        CLR_FAULT = 0;
        checkOutput(1, "clrIgnoredHold", 5'b01000, 5'b01000);
        applyStimulus(1);
        FAULT_CRIT_N = 1;
        applyStimulus(6);
        checkOutput(0, "latchHeldUntilClr", 5'b01000, 5'b01000);
        CLR_FAULT = 1;
        checkOutput(1, "clrAccepted", 5'b00000, 5'b01000);
        checkOutput(2, "clrLedsNormal", 5'b00101, 5'b11111);
        applyStimulus(1);
        CLR_FAULT = 0;
        applyStimulus(2);

        // Crit has priority over warn; after clearing, warn pattern shows.
        FAULT_CRIT_N = 0;
        FAULT_WARN_N = 0;
        applyStimulus(6);
        pat = 5'b10110;
        for (int k = 0; k < 4; k++) begin
            v = pat[k];
            CLK_4HZ = v;
            CLK_4HZ_3500MS = ~v;
            checkOutput(1, "critOverWarn", {4'b0111, ~v}, 5'b11111);
            applyStimulus(1);
        end
        FAULT_CRIT_N = 1;
        applyStimulus(6);
        CLR_FAULT = 1;
        checkOutput(1, "warnClr", 5'b00000, 5'b01000);
        applyStimulus(1);
        CLR_FAULT = 0;
        pat = 5'b01011;
        for (int k = 0; k < 4; k++) begin
            v = pat[k];
            CLK_4HZ_3500MS = v;
            CLK_4HZ = ~v;
            checkOutput(1, "warnAmber", {4'b0011, ~v}, 5'b11111);
            applyStimulus(1);
        end
        FAULT_WARN_N = 1;
        applyStimulus(8);
        checkOutput(0, "warnGone", 5'b00101, 5'b11111);

        // Identify: blue follows CLK_2HZ and times out after 3 CLK_1HZ rises.
        ID_REQ = 1;
        applyStimulus(1);
        pat = 5'b00101;
        for (int k = 0; k < 3; k++) begin
            v = pat[k];
            CLK_2HZ = v;
            checkOutput(1, "idBlue", {2'b00, ~v, 2'b01}, 5'b11111);
            applyStimulus(1);
        end
        for (int k = 0; k < 2; k++) begin
            CLK_1HZ = 1;
            applyStimulus(1);
            CLK_1HZ = 0;
            applyStimulus(1);
        end
        checkOutput(0, "idBeforeTimeout", 5'b00000, 5'b00100);
        CLK_1HZ = 1;
        checkOutput(1, "idLastLit", 5'b00000, 5'b00100);
        checkOutput(2, "idTimeout", 5'b00100, 5'b00100);
        applyStimulus(1);
        CLK_1HZ = 0;
        applyStimulus(2);
        ID_REQ = 0;
        applyStimulus(1);

        // Second request edge before timeout switches identify off.
        ID_REQ = 1;
        applyStimulus(1);
        ID_REQ = 0;
        CLK_1HZ = 1;
        applyStimulus(1);
        CLK_1HZ = 0;
        applyStimulus(1);
        ID_REQ = 1;
        checkOutput(1, "idStillOn", 5'b00000, 5'b00100);
        checkOutput(2, "idToggleOff", 5'b00100, 5'b00100);
        applyStimulus(3);
        ID_REQ = 0;
        applyStimulus(1);

        // Lamp test over a latched fault and active identify.
        CLK_4HZ = 1;
        CLK_2HZ = 1;
        FAULT_CRIT_N = 0;
        ID_REQ = 1;
        applyStimulus(1);
        ID_REQ = 0;
        applyStimulus(8);
        LAMP_TEST = 1;
        for (int d = 0; d <= 23; d++) checkOutput(d, "lampFaultId", lampExp(d, 5'b01010), 5'b11111);
        applyStimulus(1);
        LAMP_TEST = 0;
        applyStimulus(7);
        LAMP_TEST = 1;
        applyStimulus(1);
        LAMP_TEST = 0;
        applyStimulus(15);

        // Reset during the GREEN step aborts everything.
        LAMP_TEST = 1;
        applyStimulus(1);
        LAMP_TEST = 0;
        applyStimulus(11);
        checkOutput(0, "lampGreenStep", 5'b11101, 5'b11111);
        RESET = 1;
        FAULT_CRIT_N = 1;
        checkOutput(1, "midReset", 5'b00111, 5'b11111);
        applyStimulus(1);
        RESET = 0;
        checkOutput(1, "afterReset", 5'b00101, 5'b11111);
        checkOutput(3, "afterResetIdOff", 5'b00101, 5'b11111);
        applyStimulus(3);
        LAMP_TEST = 1;
        for (int d = 0; d <= 23; d++) checkOutput(d, "lampAfterReset", lampExp(d, 5'b00101), 5'b11111);
        applyStimulus(1);
        LAMP_TEST = 0;
        applyStimulus(23);

        for (int k = 0; k < 50 && cycQ.size() != 0; k++) applyStimulus(1);
        if (cycQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending %0d required 0", cycQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
